// File: rtl/mem_access_stage.sv
// MEM-stage data memory: lane-masked sub-word stores, sign/zero-extended loads,
// branch resolution, a debug read port and a word-by-word clear after reset.
module mem_access_stage #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_pipeline_enable,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_signed,
  input  logic              i_byte_enable,
  input  logic              i_halfword_enable,
  input  logic              i_word_enable,
  input  logic [DATA_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_branch,
  input  logic              i_zero,
  input  logic [ADDR_W-1:0] i_debug_addr,
  output logic [DATA_W-1:0] o_rdata,
  output logic [DATA_W-1:0] o_debug_data,
  output logic              o_branch_taken,
  output logic              o_misaligned,
  output logic              o_ready
);

  // state | meaning
  // ------+------------------------------------------------------------
  // CLEAR | writing 0 to mem[ptr] once per cycle; all outputs held at 0
  // READY | memory usable; loads, stores and debug reads are live
  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              active;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        offset;
  logic              size_word, size_half, size_byte;
  logic              misaligned_raw;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] store_mask, store_data, merged_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_widx;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [DATA_W-1:0] load_data;
  logic              unused_addr_bits;

  assign active   = !i_reset && (state == READY);
  assign word_idx = i_addr[ADDR_W+1:2];
  assign offset   = i_addr[1:0];
  // Address bits above the array wrap modulo DEPTH*4 and are deliberately dropped.
  assign unused_addr_bits = ^i_addr[DATA_W-1:ADDR_W+2];

  assign size_word = i_word_enable | ~(i_halfword_enable | i_byte_enable);
  assign size_half = ~i_word_enable & i_halfword_enable;
  assign size_byte = ~i_word_enable & ~i_halfword_enable & i_byte_enable;

  assign misaligned_raw = (size_half & offset[0]) | (size_word & (offset != 2'b00));
  assign cur_word       = mem[word_idx];

  always_comb begin
    store_mask = '0;
    store_data = '0;
    if (size_word) begin
      store_mask = '1;
      store_data = i_wdata;
    end else if (size_half) begin
      store_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF} << {offset[1], 4'b0000};
      store_data = {(DATA_W/16){i_wdata[15:0]}};
    end else if (size_byte) begin
      store_mask = {{(DATA_W-8){1'b0}}, 8'hFF} << {offset, 3'b000};
      store_data = {(DATA_W/8){i_wdata[7:0]}};
    end
  end

  assign merged_word = (cur_word & ~store_mask) | (store_data & store_mask);

  assign lane_byte = cur_word[{offset, 3'b000} +: 8];
  assign lane_half = offset[1] ? cur_word[16 +: 16] : cur_word[0 +: 16];

  always_comb begin
    load_data = '0;
    if (size_word)
      load_data = cur_word;
    else if (size_half)
      load_data = {{(DATA_W-16){i_signed & lane_half[15]}}, lane_half};
    else if (size_byte)
      load_data = {{(DATA_W-8){i_signed & lane_byte[7]}}, lane_byte};
  end

  assign o_ready        = active;
  assign o_misaligned   = active & (i_mem_read | i_mem_write) & misaligned_raw;
  assign o_rdata        = (active & i_mem_read & ~misaligned_raw) ? load_data : '0;
  assign o_debug_data   = active ? mem[i_debug_addr] : '0;
  assign o_branch_taken = active & i_branch & i_zero;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    mem_we     = 1'b0;
    mem_widx   = word_idx;
    mem_wdata  = merged_word;
    if (!i_reset) begin
      case (state)
        CLEAR: begin
          mem_we    = 1'b1;
          mem_widx  = ptr;
          mem_wdata = '0;
          ptr_next  = ptr + ADDR_W'(1);
          if (ptr == ADDR_W'(DEPTH-1))
            state_next = READY;
        end
        READY: mem_we = i_pipeline_enable & i_mem_write & ~misaligned_raw;
        default: state_next = CLEAR;
      endcase
    end
  end

  // Single write port shared by the clear sequence and pipeline stores.
  always_ff @(posedge i_clock) begin
    if (mem_we)
      mem[mem_widx] <= mem_wdata;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected values are queued as stimulus
// is driven and popped against the combinational outputs away from the clock edge.
module tb_mem_access_stage;
  localparam int S_RDATA = 0, S_DEBUG = 1, S_READY = 2, S_MIS = 3, S_BR = 4;
  localparam logic [2:0] NOP = 3'b000, LDU = 3'b100, LDS = 3'b101, ST = 3'b010, LDSST = 3'b111;
  localparam logic [2:0] SZ_N = 3'b000, SZ_B = 3'b001, SZ_H = 3'b010, SZ_W = 3'b100;

  logic        clock = 1'b0;
  logic        reset = 1'b1, pe = 1'b0, rd = 1'b0, wr = 1'b0, sgn = 1'b0;
  logic        be = 1'b0, he = 1'b0, we = 1'b0, br = 1'b0, zr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [6:0]  dbg = '0;
  logic [31:0] rdata, debug_data;
  logic        branch_taken, misaligned, ready;

  typedef struct { int sel; string name; logic [31:0] val; } exp_t;
  exp_t sb[$];
  int n_pass = 0, n_total = 0;

  always #5 clock = ~clock;

  mem_access_stage dut (
    .i_clock(clock), .i_reset(reset), .i_pipeline_enable(pe),
    .i_mem_read(rd), .i_mem_write(wr), .i_signed(sgn),
    .i_byte_enable(be), .i_halfword_enable(he), .i_word_enable(we),
    .i_addr(addr), .i_wdata(wdata), .i_branch(br), .i_zero(zr),
    .i_debug_addr(dbg), .o_rdata(rdata), .o_debug_data(debug_data),
    .o_branch_taken(branch_taken), .o_misaligned(misaligned), .o_ready(ready)
  );

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_RDATA: return rdata;
      S_DEBUG: return debug_data;
      S_READY: return {31'b0, ready};
      S_MIS:   return {31'b0, misaligned};
      default: return {31'b0, branch_taken};
    endcase
  endfunction

  task automatic drive(input logic [2:0] rws, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d);
    {rd, wr, sgn} = rws;
    {we, he, be}  = sz;
    addr  = a;
    wdata = d;
  endtask

  task automatic push(input int sel, input string name, input logic [31:0] val);
    exp_t x;
    x.sel = sel; x.name = name; x.val = val;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    exp_t x; logic [31:0] got;
    @(negedge clock);
    reset = 1'b1; pe = 1'b1; br = 1'b1; zr = 1'b1;
    drive(LDU, SZ_W, 32'h0, 32'h0);
    push(S_READY, "reset_ready", 32'h0);
    push(S_BR, "reset_branch", 32'h0);
    push(S_RDATA, "reset_rdata", 32'h0);
    #2;
    while (sb.size() > 0) begin
      x = sb.pop_front(); got = observe(x.sel); n_total++;
      if (got === x.val) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", x.name, got, x.val);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int c = 1; c <= 128; c++) begin
      @(negedge clock);
      if (c == 1) begin
        push(S_BR, "clear_branch", 32'h0);
        push(S_DEBUG, "clear_debug", 32'h0);
      end
      if (c == 127) push(S_READY, "clear_ready_127", 32'h0);
      if (c == 128) push(S_READY, "clear_ready_128", 32'h1);
      #2;
      while (sb.size() > 0) begin
        x = sb.pop_front(); got = observe(x.sel); n_total++;
        if (got === x.val) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", x.name, got, x.val);
      end
    end
    br = 1'b0; zr = 1'b0;
    drive(NOP, SZ_W, 32'h0, 32'h0);
    for (int i = 0; i < 128; i++) begin
      @(negedge clock);
      dbg = 7'(i);
      push(S_DEBUG, $sformatf("cleared_word_%0d", i), 32'h0);
      #2;
      while (sb.size() > 0) begin
        x = sb.pop_front(); got = observe(x.sel); n_total++;
        if (got === x.val) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", x.name, got, x.val);
      end
    end
  endtask

  task automatic test_store_load();
    exp_t x; logic [31:0] got;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      pe = 1'b1;
      case (i)
        0: drive(ST, SZ_W, 32'h10, 32'hDEADBEEF);
        1: begin drive(LDS, SZ_B, 32'h11, 32'h0); push(S_RDATA, "lb_0x11", 32'hFFFFFFBE); end
        2: begin drive(LDU, SZ_B, 32'h11, 32'h0); push(S_RDATA, "lbu_0x11", 32'h000000BE); end
        3: begin drive(LDS, SZ_B, 32'h13, 32'h0); push(S_RDATA, "lb_0x13", 32'hFFFFFFDE); end
        4: begin drive(LDS, SZ_H, 32'h12, 32'h0); push(S_RDATA, "lh_0x12", 32'hFFFFDEAD); end
        5: begin drive(LDU, SZ_H, 32'h12, 32'h0); push(S_RDATA, "lhu_0x12", 32'h0000DEAD); end
        6: begin drive(LDU, SZ_W, 32'h10, 32'h0); push(S_RDATA, "lw_0x10", 32'hDEADBEEF); end
        default: begin drive(NOP, SZ_W, 32'h10, 32'h0); push(S_RDATA, "no_read_rdata", 32'h0); end
      endcase
      #2;
      while (sb.size() > 0) begin
        x = sb.pop_front(); got = observe(x.sel); n_total++;
        if (got === x.val) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", x.name, got, x.val);
      end
    end
  endtask

  task automatic test_sub_word();
    exp_t x; logic [31:0] got;
    dbg = 7'd8;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      case (i)
        0: drive(ST, SZ_W, 32'h20, 32'h11223344);
        1: begin
          drive(LDSST, SZ_B, 32'h22, 32'hFFFFFF5A);
          push(S_RDATA, "sb_same_cycle_rdata", 32'h00000022);
          push(S_DEBUG, "sb_same_cycle_debug", 32'h11223344);
        end
        2: begin drive(NOP, SZ_W, 32'h20, 32'h0); push(S_DEBUG, "sb_0x22_word", 32'h115A3344); end
        3: begin drive(LDS, SZ_H, 32'h22, 32'h0); push(S_RDATA, "lh_0x22", 32'h0000115A); end
        4: drive(ST, SZ_H, 32'h20, 32'hABCD8001);
        5: begin
          drive(LDS, SZ_H, 32'h20, 32'h0);
          push(S_RDATA, "lh_0x20", 32'hFFFF8001);
          push(S_DEBUG, "sh_0x20_word", 32'h115A8001);
        end
        default: begin drive(LDS, SZ_B, 32'h21, 32'h0); push(S_RDATA, "lb_0x21", 32'hFFFFFF80); end
      endcase
      #2;
      while (sb.size() > 0) begin
        x = sb.pop_front(); got = observe(x.sel); n_total++;
        if (got === x.val) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", x.name, got, x.val);
      end
    end
  endtask

  task automatic test_misaligned();
    exp_t x; logic [31:0] got;
    dbg = 7'd8;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      case (i)
        0: begin drive(ST, SZ_H, 32'h21, 32'h00001234); push(S_MIS, "sh_0x21_flag", 32'h1); end
        1: begin
          drive(ST, SZ_W, 32'h22, 32'h0);
          push(S_MIS, "sw_0x22_flag", 32'h1);
          push(S_DEBUG, "sh_0x21_nowrite", 32'h115A8001);
        end
        2: begin
          drive(LDU, SZ_W, 32'h23, 32'h0);
          push(S_RDATA, "lw_0x23_rdata", 32'h0);
          push(S_MIS, "lw_0x23_flag", 32'h1);
          push(S_DEBUG, "sw_0x22_nowrite", 32'h115A8001);
        end
        3: begin
          drive(LDU, SZ_H, 32'h22, 32'h0);
          push(S_RDATA, "lhu_0x22", 32'h0000115A);
          push(S_MIS, "lhu_0x22_flag", 32'h0);
        end
        4: begin
          drive(LDU, SZ_B, 32'h23, 32'h0);
          push(S_RDATA, "lbu_0x23", 32'h00000011);
          push(S_MIS, "lbu_0x23_flag", 32'h0);
        end
        5: begin drive(NOP, SZ_W, 32'h23, 32'h0); push(S_MIS, "no_access_flag", 32'h0); end
        6: begin
          drive(LDS, SZ_H, 32'h23, 32'h0);
          push(S_RDATA, "lh_0x23_rdata", 32'h0);
          push(S_MIS, "lh_0x23_flag", 32'h1);
        end
        default: begin drive(LDU, SZ_W, 32'h20, 32'h0); push(S_RDATA, "lw_0x20_after", 32'h115A8001); end
      endcase
      #2;
      while (sb.size() > 0) begin
        x = sb.pop_front(); got = observe(x.sel); n_total++;
        if (got === x.val) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", x.name, got, x.val);
      end
    end
  endtask

  task automatic test_enable_branch();
    exp_t x; logic [31:0] got;
    dbg = 7'd12;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      case (i)
        0: begin pe = 1'b0; drive(ST, SZ_W, 32'h30, 32'hCAFEF00D); end
        1: begin
          drive(LDU, SZ_W, 32'h20, 32'h0); br = 1'b1; zr = 1'b1;
          push(S_RDATA, "disabled_lw_0x20", 32'h115A8001);
          push(S_DEBUG, "disabled_sw_nowrite", 32'h0);
          push(S_BR, "branch_taken_1_1", 32'h1);
        end
        2: begin drive(NOP, SZ_W, 32'h0, 32'h0); br = 1'b1; zr = 1'b0; push(S_BR, "branch_1_0", 32'h0); end
        3: begin
          pe = 1'b1; br = 1'b0; zr = 1'b1;
          drive(ST, SZ_W, 32'h30, 32'hCAFEF00D);
          push(S_BR, "branch_0_1", 32'h0);
        end
        default: begin
          drive(NOP, SZ_W, 32'h0, 32'h0); br = 1'b0; zr = 1'b0;
          push(S_DEBUG, "enabled_sw_0x30", 32'hCAFEF00D);
        end
      endcase
      #2;
      while (sb.size() > 0) begin
        x = sb.pop_front(); got = observe(x.sel); n_total++;
        if (got === x.val) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", x.name, got, x.val);
      end
    end
  endtask

  task automatic test_size_wrap();
    exp_t x; logic [31:0] got;
    dbg = 7'd16;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      case (i)
        0: drive(ST, SZ_N, 32'h40, 32'h87654321);
        1: begin
          drive(LDU, 3'b111, 32'h40, 32'h0);
          push(S_RDATA, "all_sizes_is_word", 32'h87654321);
          push(S_DEBUG, "no_size_store_word", 32'h87654321);
        end
        2: begin drive(LDS, 3'b011, 32'h42, 32'h0); push(S_RDATA, "half_over_byte", 32'hFFFF8765); end
        3: begin drive(LDU, SZ_W, 32'h240, 32'h0); push(S_RDATA, "lw_wrap_0x240", 32'h87654321); end
        4: drive(ST, SZ_B, 32'hFFFFFE40, 32'h00000099);
        default: begin
          drive(LDS, SZ_B, 32'h40, 32'h0);
          push(S_RDATA, "lb_after_wrap_sb", 32'hFFFFFF99);
          push(S_DEBUG, "wrap_sb_word", 32'h87654399);
        end
      endcase
      #2;
      while (sb.size() > 0) begin
        x = sb.pop_front(); got = observe(x.sel); n_total++;
        if (got === x.val) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", x.name, got, x.val);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t x; logic [31:0] got;
    @(negedge clock);
    reset = 1'b1; br = 1'b1; zr = 1'b1; dbg = 7'd16;
    drive(LDU, SZ_W, 32'h41, 32'h0);
    push(S_READY, "ready_in_reset", 32'h0);
    push(S_RDATA, "rdata_in_reset", 32'h0);
    push(S_DEBUG, "debug_in_reset", 32'h0);
    push(S_BR, "branch_in_reset", 32'h0);
    push(S_MIS, "mis_in_reset", 32'h0);
    #2;
    while (sb.size() > 0) begin
      x = sb.pop_front(); got = observe(x.sel); n_total++;
      if (got === x.val) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", x.name, got, x.val);
    end
    @(negedge clock);
    reset = 1'b0; br = 1'b0; zr = 1'b0;
    drive(NOP, SZ_W, 32'h0, 32'h0);
    repeat (60) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int c = 1; c <= 128; c++) begin
      @(negedge clock);
      if (c == 127) push(S_READY, "restart_ready_127", 32'h0);
      if (c == 128) push(S_READY, "restart_ready_128", 32'h1);
      #2;
      while (sb.size() > 0) begin
        x = sb.pop_front(); got = observe(x.sel); n_total++;
        if (got === x.val) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", x.name, got, x.val);
      end
    end
    for (int i = 0; i < 128; i++) begin
      @(negedge clock);
      dbg = 7'(i);
      push(S_DEBUG, $sformatf("recleared_word_%0d", i), 32'h0);
      #2;
      while (sb.size() > 0) begin
        x = sb.pop_front(); got = observe(x.sel); n_total++;
        if (got === x.val) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", x.name, got, x.val);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_load();
    test_sub_word();
    test_misaligned();
    test_enable_branch();
    test_size_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
